// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr: registered N-input priority encoder / arbiter.
//
// On each load, this block picks one requester from `in`. The pick is either
// fixed priority (the highest index wins) or round-robin (a rotating pointer
// sets the priority). The result is registered as an encoded index plus a
// one-hot grant, and it uses a valid/ready handshake. While the consumer
// stalls, the grant is held.
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   in     request vector, bit i = source i
//   mode   0 = fixed priority, 1 = round-robin (sampled at load only)
//   ready  consumer accepts the current grant this cycle
//   out    encoded index of the granted source
//   grant  one-hot grant (1 << out when valid, else 0)
//   valid  out/grant hold a live grant
module prio_arbiter_rr #(
    parameter int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         mode,
    input  logic         ready,
    output logic [W-1:0] out,
    output logic [N-1:0] grant,
    output logic         valid
);

    logic [W-1:0] out_q, out_d;
    logic [N-1:0] grant_q, grant_d;
    logic         valid_q, valid_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         load;
    logic         accept;
    logic         any_req;
    logic [W-1:0] sel_fix;
    logic [W-1:0] sel_rr;
    logic [W-1:0] sel;

    // Pointer update on acceptance in round-robin mode. The wrap goes to N-1,
    // not to 2^W-1, so non-power-of-two N never points at a missing source.
    always_comb begin
        accept = valid_q && ready;
        ptr_d  = ptr_q;
        if (accept && mode) begin
            ptr_d = (out_q == '0) ? W'(N - 1) : out_q - W'(1);
        end
    end

    // Fixed priority: ascending scan with the last hit kept, so the MSB wins.
    always_comb begin
        sel_fix = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (in[i]) begin
                sel_fix = W'(i);
            end
        end
    end

    // Round-robin: the search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
    // The scan runs from the farthest offset to the nearest, so the nearest
    // hit is kept. The search uses the post-update pointer. When a grant is
    // accepted, this stops the same source from winning again straight away
    // while others are waiting.
    always_comb begin
        sel_rr = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr_d) - k;
            if (j < 0) begin
                j = j + int'(N);
            end
            if (in[j]) begin
                sel_rr = W'(j);
            end
        end
    end

    always_comb begin
        load    = !valid_q || ready;
        any_req = |in;
        sel     = mode ? sel_rr : sel_fix;

        out_d   = out_q;
        grant_d = grant_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = any_req;
            out_d   = any_req ? sel : '0;
            grant_d = '0;
            if (any_req) begin
                grant_d[sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= W'(N - 1);
        end else begin
            out_q   <= out_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out   = out_q;
    assign grant = grant_q;
    assign valid = valid_q;

endmodule
